// File: rtl/fixedpoint_addsub_acc.sv
`default_nettype none
// ============================================================================
// Module      : fixedpoint_addsub_acc
// Description : Two-stage sign-magnitude fixed-point add/sub/accumulate unit
//               with valid/ready handshake and saturate-or-wrap overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fixedpoint_addsub_acc #(
    parameter int N   = 16,
    parameter int Q   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [1:0]   i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_c,
    output logic         o_ovf,
    output logic [N-1:0] o_acc
);

    localparam logic [1:0]   c_OP_ADD   = 2'b00;
    localparam logic [1:0]   c_OP_SUB   = 2'b01;
    localparam logic [1:0]   c_OP_ACC   = 2'b10;
    localparam logic [N-2:0] c_MAG_ONES = {(N-1){1'b1}};

    // The fractional-bit count never affects the arithmetic; it only has to be legal.
    if (N < 3 || Q < 0 || Q > N - 2) begin : g_param_check
    end

    logic         w_en;
    logic         r_s1_valid;
    logic [1:0]   r_s1_op;
    logic [N-1:0] r_s1_a;
    logic [N-1:0] r_s1_b;
    logic         r_s2_valid;
    logic [N-1:0] r_c;
    logic         r_ovf;
    logic [N-1:0] r_acc;

    logic [N-1:0] w_x;
    logic [N-1:0] w_y;
    logic [N-2:0] w_ma;
    logic [N-2:0] w_mb;
    logic         w_sa;
    logic         w_sb;
    logic [N-1:0] w_sum;
    logic [N-2:0] w_mag;
    logic         w_sign;
    logic         w_ovf;
    logic [N-1:0] w_c;

    always_comb begin
        w_en    = !r_s2_valid || i_ready;
        o_ready = w_en && !i_rst;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 2'b00;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_en) begin
            r_s1_valid <= i_valid && o_ready;
            r_s1_op    <= i_op;
            r_s1_a     <= i_a;
            r_s1_b     <= i_b;
        end
    end

    // Operand select; a load is evaluated as a + (+0), which yields a with no overflow.
    always_comb begin
        w_x = r_s1_a;
        w_y = '0;
        case (r_s1_op)
            c_OP_ADD: w_y = r_s1_b;
            c_OP_SUB: w_y = {~r_s1_b[N-1], r_s1_b[N-2:0]};
            c_OP_ACC: begin
                w_x = r_acc;
                w_y = r_s1_a;
            end
            default:  w_y = '0;
        endcase
    end

    always_comb begin
        w_ma   = w_x[N-2:0];
        w_mb   = w_y[N-2:0];
        w_sa   = w_x[N-1] && (|w_ma);
        w_sb   = w_y[N-1] && (|w_mb);
        w_sum  = {1'b0, w_ma} + {1'b0, w_mb};
        w_ovf  = 1'b0;
        w_mag  = '0;
        w_sign = 1'b0;
        if (w_sa == w_sb) begin
            w_ovf  = w_sum[N-1];
            w_mag  = (w_sum[N-1] && SAT) ? c_MAG_ONES : w_sum[N-2:0];
            w_sign = w_sa;
        end else if (w_ma >= w_mb) begin
            w_mag  = w_ma - w_mb;
            w_sign = w_sa;
        end else begin
            w_mag  = w_mb - w_ma;
            w_sign = w_sb;
        end
        // Zero magnitude (including a wrapped carry) is always emitted as +0.
        w_c = {w_sign && (|w_mag), w_mag};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_c        <= '0;
            r_ovf      <= 1'b0;
            r_acc      <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_c   <= w_c;
                r_ovf <= w_ovf;
                if (r_s1_op[1]) begin
                    r_acc <= w_c;
                end
            end
        end
    end

    assign o_valid = r_s2_valid;
    assign o_c     = r_c;
    assign o_ovf   = r_ovf;
    assign o_acc   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_fixedpoint_addsub_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixedpoint_addsub_acc
// Description : Directed bench for fixedpoint_addsub_acc, N=8 Q=4, SAT=1 and SAT=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixedpoint_addsub_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_ready;

    logic       ready,   ready_w;
    logic       valid,   valid_w;
    logic [7:0] c,       c_w;
    logic       ovf,     ovf_w;
    logic [7:0] acc,     acc_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fixedpoint_addsub_acc #(.N(8), .Q(4), .SAT(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(ready),
        .i_op(op), .i_a(a), .i_b(b), .o_valid(valid), .i_ready(out_ready),
        .o_c(c), .o_ovf(ovf), .o_acc(acc)
    );

    fixedpoint_addsub_acc #(.N(8), .Q(4), .SAT(1'b0)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(ready_w),
        .i_op(op), .i_a(a), .i_b(b), .o_valid(valid_w), .i_ready(out_ready),
        .o_c(c_w), .o_ovf(ovf_w), .o_acc(acc_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated transaction: result must appear exactly two edges after acceptance.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] ec, input logic eo,
                         input logic [7:0] ecw, input logic eow);
        op = o; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_early"}, {7'd0, valid}, 8'd0);
        tick();
        chk({tag, "_v"},    {7'd0, valid}, 8'd1);
        chk({tag, "_c"},    c, ec);
        chk({tag, "_ovf"},  {7'd0, ovf}, {7'd0, eo});
        chk({tag, "_cw"},   c_w, ecw);
        chk({tag, "_ovfw"}, {7'd0, ovf_w}, {7'd0, eow});
        tick();
        chk({tag, "_done"}, {7'd0, valid}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", {7'd0, ready}, 8'd0);
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_c",     c, 8'h00);
        chk("rst_ovf",   {7'd0, ovf}, 8'd0);
        chk("rst_acc",   acc, 8'h00);
        rst = 1'b0;
        #1;
        chk("rel_ready", {7'd0, ready}, 8'd1);

        do_op("mixed_add", 2'b00, 8'h30, 8'h98, 8'h18, 1'b0, 8'h18, 1'b0);
        do_op("sub",       2'b01, 8'h18, 8'h30, 8'h98, 1'b0, 8'h98, 1'b0);
        do_op("pos_ovf",   2'b00, 8'h70, 8'h20, 8'h7F, 1'b1, 8'h10, 1'b1);
        do_op("neg_ovf",   2'b00, 8'hF0, 8'hA0, 8'hFF, 1'b1, 8'h90, 1'b1);
        do_op("wrap_zero", 2'b00, 8'h40, 8'h40, 8'h7F, 1'b1, 8'h00, 1'b1);
        do_op("max_edge",  2'b00, 8'h7E, 8'h01, 8'h7F, 1'b0, 8'h7F, 1'b0);
        do_op("cancel",    2'b00, 8'h25, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0);
        do_op("neg_zero",  2'b00, 8'h80, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        do_op("sub_neg",   2'b01, 8'h85, 8'h05, 8'h8A, 1'b0, 8'h8A, 1'b0);
        chk("acc_untouched", acc, 8'h00);

        // Back-to-back load / accumulate / accumulate.
        op = 2'b11; a = 8'h10; in_valid = 1'b1;
        tick();
        op = 2'b10; a = 8'h20;
        tick();
        chk("acc1_c",   c, 8'h10);
        chk("acc1_acc", acc, 8'h10);
        op = 2'b10; a = 8'h85;
        tick();
        in_valid = 1'b0;
        chk("acc2_c",   c, 8'h30);
        chk("acc2_acc", acc, 8'h30);
        tick();
        chk("acc3_c",    c, 8'h2B);
        chk("acc3_acc",  acc, 8'h2B);
        chk("acc3_accw", acc_w, 8'h2B);
        tick();
        chk("acc_done", {7'd0, valid}, 8'd0);

        // Four adds with a three-cycle output stall starting on the first result.
        op = 2'b00; b = 8'h10; a = 8'h01; in_valid = 1'b1;
        tick();
        a = 8'h02;
        tick();
        a = 8'h03;
        out_ready = 1'b0;
        #1;
        chk("bp0_ready", {7'd0, ready}, 8'd0);
        chk("bp0_c",     c, 8'h11);
        tick();
        chk("bp1_ready", {7'd0, ready}, 8'd0);
        chk("bp1_c",     c, 8'h11);
        chk("bp1_v",     {7'd0, valid}, 8'd1);
        tick();
        chk("bp2_ready", {7'd0, ready}, 8'd0);
        chk("bp2_c",     c, 8'h11);
        out_ready = 1'b1;
        #1;
        chk("bp_release", {7'd0, ready}, 8'd1);
        tick();
        chk("bp_r2", c, 8'h12);
        a = 8'h04;
        tick();
        in_valid = 1'b0;
        chk("bp_r3", c, 8'h13);
        tick();
        chk("bp_r4",   c, 8'h14);
        chk("bp_r4_v", {7'd0, valid}, 8'd1);
        tick();
        chk("bp_nodup", {7'd0, valid}, 8'd0);

        // Reset with two transactions in flight and acc = 0x30.
        do_op("load30", 2'b11, 8'h30, 8'h00, 8'h30, 1'b0, 8'h30, 1'b0);
        chk("load30_acc", acc, 8'h30);
        op = 2'b00; a = 8'h01; b = 8'h01; in_valid = 1'b1;
        tick();
        a = 8'h02; b = 8'h02;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {7'd0, ready}, 8'd0);
        tick();
        chk("mid_rst_valid", {7'd0, valid}, 8'd0);
        chk("mid_rst_acc",   acc, 8'h00);
        chk("mid_rst_accw",  acc_w, 8'h00);
        chk("mid_rst_c",     c, 8'h00);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", {7'd0, ready}, 8'd1);
        tick();
        chk("mid_flush", {7'd0, valid}, 8'd0);
        do_op("post_rst", 2'b00, 8'h05, 8'h83, 8'h02, 1'b0, 8'h02, 1'b0);
        do_op("acc_neg0", 2'b10, 8'h80, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
